// File: rtl/dg0045_rom_fetch_ctrl.sv
// Instruction-byte fetch controller: serves DG0045 opcode fetches from SPI NOR flash
// (mode 0, single READ) with a one-entry last-fetch buffer in front of it.
module dg0045_rom_fetch_ctrl #(
  parameter int          DIV       = 1,
  parameter logic [23:0] BASE_ADDR = 24'h000000,
  parameter logic [7:0]  RD_CMD    = 8'h03,
  parameter int          CS_GAP    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [9:0] addr,
  input  logic       flush,
  output logic [7:0] data,
  output logic       rdy,
  output logic       busy,
  output logic       spi_cs_n,
  output logic       spi_sck,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int GW = $clog2(CS_GAP + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(CS_GAP - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t          r_state;
  logic [38:0]     r_sr;
  logic [7:0]      r_rx;
  logic [5:0]      r_bit_cnt;
  logic [DW-1:0]   r_div_cnt;
  logic [GW-1:0]   r_gap_cnt;
  logic [9:0]      r_addr;
  logic [9:0]      r_buf_addr;
  logic [7:0]      r_buf_data;
  logic            r_valid;
  logic            r_drop;
  logic [7:0]      r_data;
  logic            r_rdy;
  logic            r_busy;
  logic            r_cs_n;
  logic            r_sck;
  logic            r_mosi;

  logic [23:0]     w_flash_addr;
  logic [39:0]     w_frame;
  logic            w_hit;

  // 24-bit add wraps modulo 2^24 by construction.
  assign w_flash_addr = BASE_ADDR + {14'b0, addr};
  assign w_frame      = {RD_CMD, w_flash_addr};
  // A same-cycle flush forces a miss even if the buffer matches.
  assign w_hit        = r_valid && !flush && (addr == r_buf_addr);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_sr       <= '0;
      r_rx       <= '0;
      r_bit_cnt  <= '0;
      r_div_cnt  <= '0;
      r_gap_cnt  <= '0;
      r_addr     <= '0;
      r_buf_addr <= '0;
      r_buf_data <= '0;
      r_valid    <= 1'b0;
      r_drop     <= 1'b0;
      r_data     <= '0;
      r_rdy      <= 1'b0;
      r_busy     <= 1'b0;
      r_cs_n     <= 1'b1;
      r_sck      <= 1'b0;
      r_mosi     <= 1'b0;
    end else begin
      r_rdy <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (flush) r_valid <= 1'b0;
          // r_rdy guard keeps a held req from producing rdy on consecutive cycles.
          if (req && !r_rdy) begin
            if (w_hit) begin
              r_rdy  <= 1'b1;
              r_data <= r_buf_data;
            end else begin
              r_addr    <= addr;
              r_sr      <= w_frame[38:0];
              r_mosi    <= w_frame[39];
              r_cs_n    <= 1'b0;
              r_sck     <= 1'b0;
              r_busy    <= 1'b1;
              r_div_cnt <= '0;
              r_bit_cnt <= '0;
              r_state   <= S_SHIFT;
            end
          end
        end

        S_SHIFT: begin
          if (flush) begin
            r_valid <= 1'b0;
            r_drop  <= 1'b1;
          end
          if (r_div_cnt == DIV_LAST) begin
            r_div_cnt <= '0;
            if (!r_sck) begin
              r_sck <= 1'b1;
              if (r_bit_cnt >= 6'd40) r_rx <= {r_rx[6:0], spi_miso};
            end else if (r_bit_cnt == 6'd47) begin
              r_cs_n  <= 1'b1;
              r_sck   <= 1'b0;
              r_mosi  <= 1'b0;
              r_state <= S_DONE;
            end else begin
              // Zeros shift in behind the frame, so mosi is 0 during the data byte.
              r_sck     <= 1'b0;
              r_bit_cnt <= r_bit_cnt + 6'd1;
              r_mosi    <= r_sr[38];
              r_sr      <= {r_sr[37:0], 1'b0};
            end
          end else begin
            r_div_cnt <= r_div_cnt + DW'(1);
          end
        end

        S_DONE: begin
          r_rdy  <= 1'b1;
          r_data <= r_rx;
          r_busy <= 1'b0;
          if (flush) r_valid <= 1'b0;
          if (!r_drop && !flush) begin
            r_buf_addr <= r_addr;
            r_buf_data <= r_rx;
            r_valid    <= 1'b1;
          end
          r_drop    <= 1'b0;
          r_gap_cnt <= GW'(1);
          r_state   <= S_GAP;
        end

        S_GAP: begin
          if (flush) r_valid <= 1'b0;
          if (r_gap_cnt >= GAP_LAST) r_state <= S_IDLE;
          else r_gap_cnt <= r_gap_cnt + GW'(1);
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign data     = r_data;
  assign rdy      = r_rdy;
  assign busy     = r_busy;
  assign spi_cs_n = r_cs_n;
  assign spi_sck  = r_sck;
  assign spi_mosi = r_mosi;

endmodule

// File: tb/tb_dg0045_rom_fetch_ctrl.sv
// Bench for dg0045_rom_fetch_ctrl: two instances (DIV=1/BASE=0, DIV=3/BASE=FFFE00)
// against a behavioural SPI flash, with an expected-data queue checked on every rdy.
module tb_dg0045_rom_fetch_ctrl;

  localparam int          CLK_P  = 10;
  localparam int          CS_GAP = 2;
  localparam logic [23:0] B0     = 24'h000000;
  localparam logic [23:0] B1     = 24'hFFFE00;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #(CLK_P/2) clk = ~clk;

  logic [1:0]  req   = 2'b00;
  logic [1:0]  flush = 2'b00;
  logic [19:0] addr_p = '0;
  logic [15:0] data_p;
  logic [1:0]  rdy, busy, cs_n, sck, mosi;
  logic [1:0]  miso = 2'b00;

  dg0045_rom_fetch_ctrl #(.DIV(1), .BASE_ADDR(B0), .RD_CMD(8'h03), .CS_GAP(CS_GAP)) u_dut0 (
    .clk(clk), .rst(rst), .req(req[0]), .addr(addr_p[9:0]), .flush(flush[0]),
    .data(data_p[7:0]), .rdy(rdy[0]), .busy(busy[0]), .spi_cs_n(cs_n[0]),
    .spi_sck(sck[0]), .spi_mosi(mosi[0]), .spi_miso(miso[0])
  );

  dg0045_rom_fetch_ctrl #(.DIV(3), .BASE_ADDR(B1), .RD_CMD(8'h03), .CS_GAP(CS_GAP)) u_dut1 (
    .clk(clk), .rst(rst), .req(req[1]), .addr(addr_p[19:10]), .flush(flush[1]),
    .data(data_p[15:8]), .rdy(rdy[1]), .busy(busy[1]), .spi_cs_n(cs_n[1]),
    .spi_sck(sck[1]), .spi_mosi(mosi[1]), .spi_miso(miso[1])
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];
  logic gap_en = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    if (a == 24'h000155) return 8'hA7;
    if (a == 24'h0002AA) return 8'h3C;
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic flash_bit(input logic [23:0] a, input int idx);
    logic [7:0] b;
    b = flash_byte(a);
    return b[idx[2:0]];
  endfunction

  // Flash model: sampled at negedge, where sck/cs_n are stable between DUT edges.
  int         rise_cnt[2]  = '{0, 0};
  int         trans_cnt[2] = '{0, 0};
  int         run[2]       = '{0, 0};
  int         hi_w[2]      = '{0, 0};
  int         lo_w[2]      = '{0, 0};
  int         cs_hi[2]     = '{0, 0};
  logic [39:0] frame[2]    = '{40'h0, 40'h0};
  logic [1:0] prev_cs  = 2'b11;
  logic [1:0] prev_sck = 2'b00;

  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (prev_cs[u] && !cs_n[u]) begin
        rise_cnt[u] <= 0;
        frame[u]    <= '0;
        run[u]      <= 1;
        if (gap_en) chk("cs_gap", 64'(cs_hi[u] >= CS_GAP), 64'd1);
      end else if (!cs_n[u]) begin
        if (sck[u] && !prev_sck[u]) begin
          lo_w[u] <= run[u];
          run[u]  <= 1;
          if (rise_cnt[u] < 40) frame[u] <= {frame[u][38:0], mosi[u]};
          rise_cnt[u] <= rise_cnt[u] + 1;
        end else if (!sck[u] && prev_sck[u]) begin
          hi_w[u] <= run[u];
          run[u]  <= 1;
          if (rise_cnt[u] >= 40 && rise_cnt[u] < 48)
            miso[u] <= flash_bit(frame[u][23:0], 47 - rise_cnt[u]);
        end else begin
          run[u] <= run[u] + 1;
        end
      end
      if (!prev_cs[u] && cs_n[u]) begin
        trans_cnt[u] <= trans_cnt[u] + 1;
        miso[u]      <= 1'b0;
      end
      cs_hi[u]    <= cs_n[u] ? cs_hi[u] + 1 : 0;
      prev_cs[u]  <= cs_n[u];
      prev_sck[u] <= sck[u];
    end
  end

  // scoreboard: one expected byte per rdy
  logic [1:0] prev_rdy = 2'b00;
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (rdy[u]) begin
        if (exp_q.size() == 0) chk("sb_unexpected_rdy", 64'd1, 64'd0);
        else chk("sb_data", 64'(data_p[u*8 +: 8]), 64'(exp_q.pop_front()));
        chk("rdy_while_busy", 64'(busy[u]), 64'd0);
        chk("rdy_consecutive", 64'(prev_rdy[u]), 64'd0);
      end
    end
    prev_rdy <= rdy;
  end

  // driver tasks
  task automatic pulse_flush(input int u);
    @(negedge clk); flush[u] = 1'b1;
    @(negedge clk); flush[u] = 1'b0;
  endtask

  // flush_cyc: 0 none, 1 with the req, k>1 at the (k-1)th cycle after the req edge
  task automatic fetch(input int u, input logic [9:0] a, input int exp_lat,
                       input int flush_cyc, input string tag);
    int n, busy_n, t0;
    logic got;
    logic [23:0] base;
    base = (u == 0) ? B0 : B1;
    repeat (3) @(negedge clk);
    t0 = trans_cnt[u];
    addr_p[u*10 +: 10] = a;
    req[u] = 1'b1;
    if (flush_cyc == 1) flush[u] = 1'b1;
    exp_q.push_back(flash_byte(base + {14'b0, a}));
    n = 0; busy_n = 0; got = 1'b0;
    while (!got && n < 400) begin
      @(negedge clk);
      n++;
      req[u]   = 1'b0;
      flush[u] = (n == flush_cyc - 1);
      if (busy[u]) busy_n++;
      if (rdy[u]) got = 1'b1;
    end
    flush[u] = 1'b0;
    chk({tag, "_latency"}, 64'(n), 64'(exp_lat));
    chk({tag, "_busy_cycles"}, 64'(busy_n), 64'((exp_lat > 1) ? exp_lat - 1 : 0));
    chk({tag, "_spi_transactions"}, 64'(trans_cnt[u] - t0), 64'((exp_lat > 1) ? 1 : 0));
    chk({tag, "_cs_n_at_rdy"}, 64'(cs_n[u]), 64'd1);
    if (exp_lat > 1) begin
      chk({tag, "_frame"}, 64'(frame[u]), 64'({8'h03, base + {14'b0, a}}));
      chk({tag, "_sck_rises"}, 64'(rise_cnt[u]), 64'd48);
    end
  endtask

  initial begin
    #(CLK_P * 60000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [9:0] a;
    int n;
    logic got;

    repeat (3) @(negedge clk);
    chk("rst_cs_n", 64'(cs_n), 64'h3);
    chk("rst_sck", 64'(sck), 64'h0);
    chk("rst_mosi", 64'(mosi), 64'h0);
    chk("rst_rdy", 64'(rdy), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_data", 64'(data_p), 64'h0);
    rst = 1'b0;

    fetch(0, 10'h155, 98, 0, "miss155");
    chk("sck_low_w_div1", 64'(lo_w[0]), 64'd1);
    chk("sck_high_w_div1", 64'(hi_w[0]), 64'd1);
    fetch(0, 10'h155, 1, 0, "hit155");
    pulse_flush(0);
    fetch(0, 10'h155, 98, 0, "after_flush155");

    fetch(0, 10'h2AA, 98, 50, "flush_mid2AA");
    fetch(0, 10'h2AA, 98, 0, "refetch2AA");
    fetch(0, 10'h2AA, 1, 0, "hit2AA");
    fetch(0, 10'h2AA, 98, 1, "flush_with_req");

    for (int i = 0; i < 3; i++) begin
      a = 10'($urandom_range(0, 1023));
      pulse_flush(0);
      fetch(0, a, 98, 0, "rand_miss");
      fetch(0, a, 1, 0, "rand_hit");
    end

    // reset in the middle of SHIFT
    fetch(0, 10'h001, 98, 0, "pre_abort001");
    fetch(0, 10'h001, 1, 0, "pre_abort_hit");
    repeat (3) @(negedge clk);
    addr_p[9:0] = 10'h000;
    req[0] = 1'b1;
    @(negedge clk);
    req[0] = 1'b0;
    repeat (40) @(negedge clk);
    chk("abort_cs_active", 64'(cs_n[0]), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_cs_n", 64'(cs_n[0]), 64'd1);
    chk("abort_sck", 64'(sck[0]), 64'd0);
    chk("abort_busy", 64'(busy[0]), 64'd0);
    chk("abort_rdy", 64'(rdy[0]), 64'd0);
    chk("abort_data", 64'(data_p[7:0]), 64'd0);
    fetch(0, 10'h001, 98, 0, "post_abort001");

    // req held high with alternating addresses
    repeat (3) @(negedge clk);
    gap_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = (i % 2 == 0) ? 10'h000 : 10'h001;
      addr_p[9:0] = a;
      req[0] = 1'b1;
      exp_q.push_back(flash_byte(B0 + {14'b0, a}));
      n = 0; got = 1'b0;
      while (!got && n < 400) begin
        @(negedge clk);
        n++;
        if (rdy[0]) got = 1'b1;
      end
      chk("held_req_done", 64'(got), 64'd1);
    end
    req[0] = 1'b0;
    gap_en = 1'b0;

    // DIV=3 with wrapping base address
    fetch(1, 10'h3FF, 290, 0, "wrap3FF");
    chk("sck_low_w_div3", 64'(lo_w[1]), 64'd3);
    chk("sck_high_w_div3", 64'(hi_w[1]), 64'd3);
    fetch(1, 10'h3FF, 1, 0, "wrap_hit");

    repeat (5) @(negedge clk);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
